// File: rtl/cntr8_down.sv
// cntr8_down: 8-bit loadable down-counter/timer; start loads din, en decrements, one-cycle done pulse on expiry.
// Latency: q/busy valid one edge after start; done rises after the din-th enabled edge. Define CNTR8_DOWN_RELOAD_EN for periodic reload mode.
// Backpressure: none; en gates counting, abort cancels to IDLE, start is ignored while busy.
module cntr8_down (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       en,
  input  logic       abort,
  output logic [7:0] q,
  output logic       busy,
  output logic       done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [7:0] r_q;
  logic [7:0] w_q_nxt;
  logic       r_done;
  logic       w_done_nxt;

  logic [7:0] w_borrow;
  logic [7:0] w_dec;
  logic       w_din_zero;
  logic       w_q_one;
  logic [7:0] w_expire_q;
  logic [0:0] w_expire_state;

  // Ripple-borrow decrementer: bit i flips while every lower bit is zero.
  assign w_borrow[0] = 1'b1;
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_borrow
      assign w_borrow[gi] = ~r_q[gi-1] & w_borrow[gi-1];
    end
  endgenerate
  assign w_dec = r_q ^ w_borrow;

  // Zero-load and last-count detectors.
  assign w_din_zero = ~|din;
  assign w_q_one    = r_q[0] & ~|r_q[7:1];

`ifdef CNTR8_DOWN_RELOAD_EN
  logic [7:0] r_reload;

  // Capture the period on every accepted start so expiry can restart the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reload <= 8'h00;
    end else if ((r_state == S_IDLE) && start) begin
      r_reload <= din;
    end
  end

  assign w_expire_q     = r_reload;
  assign w_expire_state = S_RUN;
`else
  assign w_expire_q     = 8'h00;
  assign w_expire_state = S_IDLE;
`endif

  // Next-state, next-count and done-pulse decode; abort outranks expiry in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_din_zero) begin
            w_q_nxt    = 8'h00;
            w_done_nxt = 1'b1;
          end else begin
            w_q_nxt     = din;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_q_nxt     = 8'h00;
          w_state_nxt = S_IDLE;
        end else if (en) begin
          if (w_q_one) begin
            w_q_nxt     = w_expire_q;
            w_done_nxt  = 1'b1;
            w_state_nxt = w_expire_state;
          end else begin
            w_q_nxt = w_dec;
          end
        end
      end
      default: begin
        w_q_nxt     = 8'h00;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, count and done registers; reset forces IDLE with a cleared count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_q     <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign q    = r_q;
  assign busy = (r_state == S_RUN);
  assign done = r_done;

endmodule

// File: doc/cntr8_down.md
# cntr8_down

8-bit loadable down-counter/timer, the count-down counterpart to the 8-bit up-counter in the counter library. A start pulse loads an 8-bit value. The block then decrements once per enabled clock, raises a one-cycle `done` pulse on reaching zero, and returns to idle. It sits beside the up-counter as a programmable delay/interval source and is built from the shared gate primitives plus flip-flops.

## Interface
Parameters:
- None. Width is fixed at 8 bits.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  load request; sampled only in IDLE.
- `din`  in  8  load value, sampled with `start`.
- `en`  in  1  count enable; decrement only when high in RUN.
- `abort`  in  1  cancel the count; forces IDLE.
- `q`  out  8  current count value (registered).
- `busy`  out  1  high while in RUN (decoded from the state register).
- `done`  out  1  one-cycle registered pulse on expiry.

## Operation
- States: IDLE, RUN. Two-state FSM with a registered state.
- Reset (async, `rst`=1): state IDLE, `q`=0x00, `busy`=0, `done`=0. The reset is held while `rst`=1 and overrides any operation in progress.
- IDLE:
  - `start`=1 with `din`≠0: `q`←`din`, go to RUN.
  - `start`=1 with `din`=0: `q`←0, `done`←1 for one cycle, stay IDLE.
  - `start`=0: `q` holds.
  - `en` and `abort` have no effect.
- RUN, priority order:
  - `abort`=1: `q`←0, go to IDLE, `done` stays 0.
  - `en`=1 and `q`=1: `q`←0, `done`←1, go to IDLE (see Configuration for reload).
  - `en`=1 and `q`>1: `q`←`q`−1.
  - `en`=0: hold.
  - `start` is ignored in RUN. No restart and no reload of `din` mid-count.
- Arithmetic:
  - Decrement is 8-bit modulo. Underflow cannot occur, because zero is never decremented.
  - A load of 0xFF gives 255 enabled cycles to expiry.
- `done` is 0 in every cycle other than the expiry pulse.

## Timing
- `start` sampled at edge N: after edge N, `q`=`din` and `busy`=1.
- Expiry latency: `done` is high in the cycle following the edge that consumes the `din`-th enabled cycle.
  - With `en` held high, `done` rises after edge N+`din` and falls after edge N+`din`+1.
  - With `en` held high, `busy` falls after edge N+`din` in the non-reload build.
- `abort` takes effect at the next edge: `q`=0 and `busy`=0 after it.
- `abort` and expiry in the same cycle: `abort` wins and no `done` is produced.
- `rst` assertion: outputs go to reset values immediately, without waiting for `clk`.
- `rst` release: the first active edge after release is treated as IDLE.

## Configuration
Macro: `CNTR8_DOWN_RELOAD_EN`.
- Defined:
  - `start` in IDLE also captures `din` into an 8-bit reload register.
  - On expiry in RUN, `q`←reload value, `done`←1, and the FSM stays in RUN (periodic mode, period = reload value enabled cycles).
  - `abort` still returns to IDLE with `q`=0.
  - Reset clears the reload register to 0.
  - `start` with `din`=0 behaves as in the non-reload build.
- Not defined:
  - There is no reload register.
  - Expiry always returns to IDLE (one-shot mode).

## Test plan
- Reset mid-count: load 0x10 with `en`=1, assert `rst` after 5 cycles. Expect `q`=0x00, `busy`=0, `done`=0 immediately; after release the block stays in IDLE.
- One-shot count: `start`=1 with `din`=0x05 and `en` held 1. Expect `q` to step 5,4,3,2,1,0, `done` high exactly one cycle when `q` becomes 0, `busy` to fall on the same edge, and a later `start` to be accepted.
- Enable gating: `din`=0x03, with `en` toggling 1,0,0,1,0,1. Expect `q` 3→2→2→2→1→1→0, and `done` asserted only after the third enabled edge.
- Abort and zero load:
  - `din`=0x08, `abort`=1 after 2 enabled cycles: expect `q`=0, `busy`=0, no `done`.
  - Separately, `start` with `din`=0x00: expect a `done` pulse on the next cycle with `busy` never asserted.
- Boundary load and ignored `start`: `din`=0xFF with `en` held high. Expect `done` after exactly 255 enabled cycles. A `start` with `din`=0x02 issued during RUN must not change `q`.
- Reload build (`CNTR8_DOWN_RELOAD_EN` defined): `din`=0x04 with `en` held high. Expect a `done` pulse every 4 cycles, `q` sequence 4,3,2,1,4,3,…, `busy` held high; `abort` ends the sequence with `q`=0.
